local_predictor: RTL and testbench
==================================

LOCAL_PREDICTOR -- requirements
Module: local_predictor

Interface
REQ-001 Parameter S_INDEX, default 4, log2 of local-history-table (LHT) entry count.
REQ-002 Parameter HIST_W, default 4, local history length in bits; also log2 of pattern-history-table (PHT) entry count; legal range 2..16.
REQ-003 Parameter CTR_W, default 2, saturating counter width; legal range 2..4.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 rd_pc  in  32  fetch PC to predict.
REQ-007 pred_taken  out  1  combinational prediction for rd_pc.
REQ-008 pred_hist  out  HIST_W  history used to form pred_taken; carried down pipe and returned as upd_hist.
REQ-009 upd_valid  in  1  resolved-branch update strobe.
REQ-010 upd_pc  in  32  PC of resolved branch.
REQ-011 upd_hist  in  HIST_W  pred_hist value captured at prediction time.
REQ-012 upd_taken  in  1  resolved direction.
REQ-013 ready  out  1  high when table initialisation is complete.

Function
REQ-014 LHT index = rd_pc[S_INDEX+1:2] (read) / upd_pc[S_INDEX+1:2] (write); entry width HIST_W.
REQ-015 PHT read index = lht_read_hist XOR rd_pc[HIST_W+1:2]; PHT write index = upd_hist XOR upd_pc[HIST_W+1:2].
REQ-016 pred_taken = MSB of selected PHT counter; pred_hist = history used for the PHT read index.
REQ-017 Two-state FSM: INIT, READY; rst forces INIT with init counter = 0.
REQ-018 INIT: each cycle writes entry init_cnt of LHT (if < 2^S_INDEX) to all-ones and of PHT (if < 2^HIST_W) to 2^(CTR_W-1) (weakly taken), then increments init_cnt.
REQ-019 INIT lasts exactly 2^max(S_INDEX,HIST_W) cycles; transition to READY after the write of the last index.
REQ-020 In INIT: ready=0, pred_taken=0, pred_hist=0, upd_valid ignored.
REQ-021 In READY with upd_valid=1: LHT[upd idx] <= {LHT[upd idx][HIST_W-2:0], upd_taken}; same cycle PHT[write idx] updated.
REQ-022 Counter update: taken increments, saturating at 2^CTR_W-1; not-taken decrements, saturating at 0.
REQ-023 LHT forwarding: if upd_valid and read LHT index equals write LHT index, read history is the post-update value.
REQ-024 PHT forwarding: if upd_valid and final PHT read index equals PHT write index, pred_taken uses the post-update counter MSB.
REQ-025 Forwarding chain: PHT read index is computed from the forwarded history (REQ-023 before REQ-024).
REQ-026 Updates with distinct indices never disturb other entries; no read-side state change.

Reset
REQ-027 rst has priority over all other inputs, including mid-INIT and mid-update.
REQ-028 Output values during and immediately after rst: ready=0, pred_taken=0, pred_hist=0; all prior training discarded once INIT completes.
REQ-029 rst asserted in READY: ready falls in the cycle after the sampling edge; INIT restarts from index 0.

Verification (defaults S_INDEX=4, HIST_W=4, CTR_W=2)
REQ-030 Deassert rst at cycle 0 -> ready=0 for cycles 0..15, ready=1 at cycle 16; rd_pc=0x40 then gives pred_hist=0xF, pred_taken=1.
REQ-031 Update upd_pc=0x40, upd_hist=0xF, upd_taken=0 -> PHT[0xF] 2->1, LHT[0] 0xF->0xE; next rd_pc=0x40 gives pred_hist=0xE, pred_taken=1 (PHT[0xE]=2).
REQ-032 Three taken updates upd_pc=0x80, upd_hist=0xF -> PHT[0xF] 2->3->3->3; rd_pc=0x80 with hist 0x8 not affected; saturation verified. Four not-taken -> 3->2->1->0->0, MSB 0.
REQ-033 Same-cycle rd_pc=upd_pc=0x40, upd_taken=0, LHT[0]=0xF -> pred_hist=0xE combinationally that cycle.
REQ-034 PHT[0x3] set to 1, same-cycle update taken to PHT[0x3] while read maps to 0x3 -> pred_taken=1 that cycle.
REQ-035 rst pulsed for 1 cycle at cycle 8 of INIT, and again in READY after training -> ready low 16 cycles from each release; rd_pc=0x40 then gives pred_hist=0xF, pred_taken=1.

Source files
------------

// File: rtl/local_predictor.sv
// Two-level local branch predictor: per-PC local history table (LHT) indexing a
// table of saturating counters (PHT), with same-cycle update forwarding.
module local_predictor #(
    parameter int S_INDEX = 4,
    parameter int HIST_W  = 4,
    parameter int CTR_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       rd_pc,
    output logic              pred_taken,
    output logic [HIST_W-1:0] pred_hist,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic [HIST_W-1:0] upd_hist,
    input  logic              upd_taken,
    output logic              ready
);

    localparam int INIT_W = (S_INDEX > HIST_W) ? S_INDEX : HIST_W;
    localparam int LHT_N  = 1 << S_INDEX;
    localparam int PHT_N  = 1 << HIST_W;

    localparam logic [CTR_W-1:0]  CTR_ONE  = {{(CTR_W-1){1'b0}}, 1'b1};
    localparam logic [CTR_W-1:0]  CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0]  CTR_WEAK = {1'b1, {(CTR_W-1){1'b0}}};
    localparam logic [INIT_W-1:0] INIT_ONE = {{(INIT_W-1){1'b0}}, 1'b1};
    localparam logic [INIT_W-1:0] INIT_END = {INIT_W{1'b1}};

    typedef enum logic {INIT, READY} state_t;

    state_t            state_reg, state_next;
    logic [INIT_W-1:0] init_cnt_reg, init_cnt_next;

    logic [HIST_W-1:0] lht [LHT_N];
    logic [CTR_W-1:0]  pht [PHT_N];

    logic [S_INDEX-1:0] rd_lht_idx, upd_lht_idx, init_lht_idx;
    logic [HIST_W-1:0]  pht_rd_idx, pht_wr_idx, init_pht_idx;
    logic [HIST_W-1:0]  lht_wr_data, rd_hist_fwd;
    logic [CTR_W-1:0]   pht_cur, pht_wr_data, rd_ctr;
    logic               upd_en, lht_init_en, pht_init_en;
    logic               unused_pc_bits;

    assign ready  = (state_reg == READY);
    assign upd_en = upd_valid && ready;

    assign rd_lht_idx   = rd_pc[S_INDEX+1:2];
    assign upd_lht_idx  = upd_pc[S_INDEX+1:2];
    assign init_lht_idx = init_cnt_reg[S_INDEX-1:0];
    assign init_pht_idx = init_cnt_reg[HIST_W-1:0];
    assign pht_wr_idx   = upd_hist ^ upd_pc[HIST_W+1:2];

    // The init counter spans the larger table; the smaller one is only written
    // while the counter is still inside its range.
    generate
        if (INIT_W > S_INDEX) begin : g_lht_init_range
            assign lht_init_en = (init_cnt_reg[INIT_W-1:S_INDEX] == '0);
        end else begin : g_lht_init_full
            assign lht_init_en = 1'b1;
        end
        if (INIT_W > HIST_W) begin : g_pht_init_range
            assign pht_init_en = (init_cnt_reg[INIT_W-1:HIST_W] == '0);
        end else begin : g_pht_init_full
            assign pht_init_en = 1'b1;
        end
    endgenerate

    assign lht_wr_data = {lht[upd_lht_idx][HIST_W-2:0], upd_taken};

    always_comb begin
        pht_cur     = pht[pht_wr_idx];
        pht_wr_data = pht_cur;
        if (upd_taken) begin
            if (pht_cur != CTR_MAX) pht_wr_data = pht_cur + CTR_ONE;
        end else begin
            if (pht_cur != '0) pht_wr_data = pht_cur - CTR_ONE;
        end
    end

    // Read path: the history is forwarded first, then the PHT index derived
    // from it, then the counter is forwarded against the same-cycle update.
    always_comb begin
        rd_hist_fwd = lht[rd_lht_idx];
        if (upd_en && (rd_lht_idx == upd_lht_idx)) rd_hist_fwd = lht_wr_data;
        pht_rd_idx = rd_hist_fwd ^ rd_pc[HIST_W+1:2];
        rd_ctr     = pht[pht_rd_idx];
        if (upd_en && (pht_rd_idx == pht_wr_idx)) rd_ctr = pht_wr_data;
    end

    assign pred_taken = ready && rd_ctr[CTR_W-1];
    assign pred_hist  = ready ? rd_hist_fwd : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_reg == INIT) begin
                if (lht_init_en) lht[init_lht_idx] <= '1;
                if (pht_init_en) pht[init_pht_idx] <= CTR_WEAK;
            end else if (upd_valid) begin
                lht[upd_lht_idx] <= lht_wr_data;
                pht[pht_wr_idx]  <= pht_wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= INIT;
            init_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        case (state_reg)
            INIT: begin
                init_cnt_next = init_cnt_reg + INIT_ONE;
                if (init_cnt_reg == INIT_END) state_next = READY;
            end
            READY: begin
                state_next = READY;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    assign unused_pc_bits = ^{rd_pc[31:INIT_W+2], rd_pc[1:0],
                              upd_pc[31:INIT_W+2], upd_pc[1:0]};

endmodule

// File: tb/tb_local_predictor.sv
// Scoreboard bench for local_predictor: a table-level model predicts each
// cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_local_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rd_pc = '0;
    logic        pred_taken;
    logic [3:0]  pred_hist;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic [3:0]  upd_hist = '0;
    logic        upd_taken = 1'b0;
    logic        ready;

    local_predictor #(.S_INDEX(4), .HIST_W(4), .CTR_W(2)) dut (
        .clk(clk), .rst(rst), .rd_pc(rd_pc), .pred_taken(pred_taken),
        .pred_hist(pred_hist), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_hist(upd_hist), .upd_taken(upd_taken), .ready(ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tag;
        logic       ready;
        logic       taken;
        logic [3:0] hist;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;
    int   tag_cnt = 0;

    // Reference model state: plain tables plus remaining init cycles.
    int m_lht[16];
    int m_pht[16];
    int init_left = 0;
    bit known = 0;

    function automatic int sat(input int c, input bit t);
        if (t) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    function automatic int idx(input logic [31:0] pc);
        return int'((pc >> 2) & 32'hF);
    endfunction

    task automatic cycle(input bit r, input logic [31:0] rpc, input bit uv,
                         input logic [31:0] upc, input logic [3:0] uh, input bit ut);
        exp_t e;
        int li, h, pi, wi, c;
        rst = r; rd_pc = rpc; upd_valid = uv; upd_pc = upc; upd_hist = uh; upd_taken = ut;
        if (known) begin
            e.tag = tag_cnt;
            if (init_left > 0) begin
                e.ready = 0; e.taken = 0; e.hist = 0;
            end else begin
                li = idx(rpc);
                h  = m_lht[li];
                if (uv && idx(upc) == li) h = ((m_lht[li] << 1) | int'(ut)) & 15;
                pi = h ^ idx(rpc);
                wi = int'(uh) ^ idx(upc);
                c  = m_pht[pi];
                if (uv && pi == wi) c = sat(m_pht[wi], ut);
                e.ready = 1; e.taken = (c >= 2); e.hist = 4'(h);
            end
            exp_q.push_back(e);
        end
        tag_cnt++;
        @(posedge clk);
        #1;
        if (r) begin
            init_left = 16;
            known = 1;
        end else if (known && init_left > 0) begin
            init_left--;
            if (init_left == 0) begin
                for (int i = 0; i < 16; i++) begin
                    m_lht[i] = 15;
                    m_pht[i] = 2;
                end
            end
        end else if (known && uv) begin
            wi = int'(uh) ^ idx(upc);
            m_pht[wi] = sat(m_pht[wi], ut);
            li = idx(upc);
            m_lht[li] = ((m_lht[li] << 1) | int'(ut)) & 15;
        end
    endtask

    task automatic idle(input int n, input logic [31:0] rpc);
        for (int i = 0; i < n; i++) cycle(0, rpc, 0, 32'h0, 4'h0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (ready !== e.ready) begin
                fails++;
                $display("FAIL ready  cyc=%0d got=%b want=%b", e.tag, ready, e.ready);
            end
            checks++;
            if (pred_taken !== e.taken) begin
                fails++;
                $display("FAIL pred_taken cyc=%0d got=%b want=%b", e.tag, pred_taken, e.taken);
            end
            checks++;
            if (pred_hist !== e.hist) begin
                fails++;
                $display("FAIL pred_hist cyc=%0d got=%h want=%h", e.tag, pred_hist, e.hist);
            end
            $display("cyc=%0d ready=%b taken=%b hist=%h", e.tag, ready, pred_taken, pred_hist);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        // Reset, full init, then reads of a fresh table.
        cycle(1, 32'h40, 0, 32'h0, 4'h0, 0);
        idle(20, 32'h40);
        // Not-taken update then re-read.
        cycle(0, 32'h0, 1, 32'h40, 4'hF, 0);
        idle(1, 32'h40);
        // Saturation upward and downward on PHT[0xF].
        for (int i = 0; i < 3; i++) cycle(0, 32'h0C, 1, 32'h80, 4'hF, 1);
        idle(1, 32'h80);
        for (int i = 0; i < 4; i++) cycle(0, 32'h0C, 1, 32'h80, 4'hF, 0);
        idle(1, 32'h80);
        // Same-cycle LHT forwarding on a fresh table.
        cycle(1, 32'h40, 0, 32'h0, 4'h0, 0);
        idle(16, 32'h40);
        cycle(0, 32'h40, 1, 32'h40, 4'hF, 0);
        // PHT forwarding: drive PHT[3] to 1, then a taken update while read maps to 3.
        cycle(1, 32'h0, 0, 32'h0, 4'h0, 0);
        idle(16, 32'h30);
        cycle(0, 32'h30, 1, 32'h0, 4'h3, 0);
        cycle(0, 32'h30, 1, 32'h0, 4'h3, 1);
        idle(1, 32'h30);
        // Reset mid-init and again after training.
        cycle(1, 32'h40, 0, 32'h0, 4'h0, 0);
        idle(8, 32'h40);
        cycle(1, 32'h40, 0, 32'h0, 4'h0, 0);
        idle(17, 32'h40);
        for (int i = 0; i < 10; i++) cycle(0, 32'h40, 1, 32'h40, 4'(i), 1);
        cycle(1, 32'h40, 1, 32'h40, 4'h1, 0);
        idle(18, 32'h40);
        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  32'($urandom_range(0, 255)) << 2,
                  ($urandom_range(0, 3) != 0),
                  32'($urandom_range(0, 255)) << 2,
                  4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
